// File: rtl/key_debounce_pkg.sv
// ============================================================================
// key_debounce_pkg : shared FSM encoding and helpers for the key debouncer
// Revision 1.0
// ============================================================================
`default_nettype none

package key_debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PDEB    = 2'd1,
      ST_PRESSED = 2'd2,
      ST_RDEB    = 2'd3
   } key_fsm_e;

   // A key counts as held while pressed or while a release is still being qualified.
   function automatic logic key_is_down(input key_fsm_e st);
      return (st == ST_PRESSED) || (st == ST_RDEB);
   endfunction

endpackage : key_debounce_pkg

`default_nettype wire

// File: rtl/key_debounce_chan.sv
// ============================================================================
// key_debounce_chan : synchroniser, debounce FSM and hold timer for one key
// Revision 1.0
// ============================================================================
`default_nettype none

module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
)(
   input  logic clk,
   input  logic rstn,
   input  logic i_key_n,
   output logic o_state,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int c_HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES);

   logic [1:0]          r_sync;
   logic                w_s;
   key_fsm_e            r_state;
   key_fsm_e            w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_CNT_W-1:0]  w_cnt_nxt;
   logic [c_HOLD_W-1:0] r_hold;
   logic [c_HOLD_W-1:0] w_hold_nxt;
   logic                w_down_nxt;
   logic                r_down;
   logic                r_press;
   logic                r_release;
   logic                r_long;

   // Synchroniser holds the raw pin polarity, so its reset value means "released".
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_key_n};
      end
   end

   assign w_s = ~r_sync[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold_nxt  = r_hold;
      case (r_state)
         ST_IDLE: begin
            if (w_s) begin
               w_state_nxt = ST_PDEB;
               w_cnt_nxt   = '0;
            end
         end
         ST_PDEB: begin
            if (!w_s) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = '0;
               w_hold_nxt  = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            if (!w_s) begin
               w_state_nxt = ST_RDEB;
               w_cnt_nxt   = '0;
            end else if (r_hold != c_HOLD_MAX) begin
               w_hold_nxt = r_hold + c_HOLD_W'(1);
            end
         end
         ST_RDEB: begin
            // Hold time is preserved across a release bounce so key_long cannot re-fire.
            if (w_s) begin
               w_state_nxt = ST_PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_hold_nxt  = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   assign w_down_nxt = key_is_down(w_state_nxt);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_down    <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_down    <= w_down_nxt;
         r_press   <= w_down_nxt & ~r_down;
         r_release <= ~w_down_nxt & r_down;
         r_long    <= (w_hold_nxt == c_HOLD_MAX) && (r_hold != c_HOLD_MAX);
      end
   end

   assign o_state   = r_down;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;

endmodule : key_debounce_chan

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : NUM_KEYS independent active-low pushbutton debouncers
// Revision 1.0
// ============================================================================
`default_nettype none

module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
         key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
         ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .i_key_n   (key_n[gi]),
            .o_state   (key_state[gi]),
            .o_press   (key_press[gi]),
            .o_release (key_release[gi]),
            .o_long    (key_long[gi])
         );
      end
   endgenerate

endmodule : key_debounce

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// tb_key_debounce : directed self-checking bench for key_debounce (D=8, L=32)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce;

   localparam int c_KEYS = 4;
   localparam int c_DEB  = 8;
   localparam int c_LONG = 32;
   localparam int c_LAT  = c_DEB + 3;

   logic              clk;
   logic              rstn;
   logic [c_KEYS-1:0] key_n;
   logic [c_KEYS-1:0] key_state;
   logic [c_KEYS-1:0] key_press;
   logic [c_KEYS-1:0] key_release;
   logic [c_KEYS-1:0] key_long;

   int n_checks;
   int n_errors;
   int press_cnt   [c_KEYS];
   int release_cnt [c_KEYS];
   int long_cnt    [c_KEYS];
   int overlap_cnt;

   key_debounce #(
      .NUM_KEYS        (c_KEYS),
      .DEBOUNCE_CYCLES (c_DEB),
      .LONG_CYCLES     (c_LONG)
   ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      overlap_cnt = 0;
      for (int k = 0; k < c_KEYS; k++) begin
         press_cnt[k]   = 0;
         release_cnt[k] = 0;
         long_cnt[k]    = 0;
      end
   end

   // Pulse tally, sampled mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < c_KEYS; k++) begin
         if (key_press[k])   press_cnt[k]++;
         if (key_release[k]) release_cnt[k]++;
         if (key_long[k])    long_cnt[k]++;
         if (key_press[k] && key_release[k]) overlap_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind 0 = press, 1 = release, 2 = long; n = edges until first non-zero vector, -1 on timeout
   task automatic wait_pulse(input int kind, output int n, output logic [c_KEYS-1:0] vec);
      n   = -1;
      vec = '0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         case (kind)
            0:       vec = key_press;
            1:       vec = key_release;
            default: vec = key_long;
         endcase
         if (vec != '0) begin
            n = i;
            break;
         end
      end
   endtask

   int                n;
   logic [c_KEYS-1:0] v;
   int                snap;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rstn     = 1'b0;
      key_n    = 4'b0000;

      // 1: reset with all keys held
      repeat (3) tick();
      chk("rst_state",   32'(key_state),   32'h0);
      chk("rst_press",   32'(key_press),   32'h0);
      chk("rst_release", 32'(key_release), 32'h0);
      chk("rst_long",    32'(key_long),    32'h0);
      rstn = 1'b1;
      wait_pulse(0, n, v);
      chk("rst_press_lat", 32'(n), 32'(c_LAT));
      chk("rst_press_vec", 32'(v), 32'hF);
      tick();
      chk("rst_press_width", 32'(key_press), 32'h0);
      chk("rst_state_on",    32'(key_state), 32'hF);
      key_n = 4'b1111;
      wait_pulse(1, n, v);
      chk("rst_rel_lat", 32'(n), 32'(c_LAT));
      chk("rst_rel_vec", 32'(v), 32'hF);
      chk("rst_state_off", 32'(key_state), 32'h0);
      tick();

      // 2: clean press of key0, held 20 cycles
      key_n[0] = 1'b0;
      wait_pulse(0, n, v);
      chk("k0_press_lat", 32'(n), 32'(c_LAT));
      chk("k0_press_vec", 32'(v), 32'h1);
      chk("k0_state",     32'(key_state), 32'h1);
      tick();
      chk("k0_press_width", 32'(key_press), 32'h0);
      repeat (8) tick();
      key_n[0] = 1'b1;
      wait_pulse(1, n, v);
      chk("k0_rel_lat", 32'(n), 32'(c_LAT));
      chk("k0_rel_vec", 32'(v), 32'h1);
      tick();
      chk("k0_rel_width", 32'(key_release), 32'h0);
      chk("k0_no_long",   32'(long_cnt[0]), 32'h0);

      // 3: key1 bounces (low 5 / high 2) four times, then held
      snap = press_cnt[1];
      repeat (4) begin
         key_n[1] = 1'b0;
         repeat (5) tick();
         key_n[1] = 1'b1;
         repeat (2) tick();
      end
      chk("k1_bounce_state", 32'(key_state[1]), 32'h0);
      chk("k1_bounce_press", 32'(press_cnt[1] - snap), 32'h0);
      key_n[1] = 1'b0;
      wait_pulse(0, n, v);
      chk("k1_press_lat", 32'(n), 32'(c_LAT));
      chk("k1_press_vec", 32'(v), 32'h2);
      key_n[1] = 1'b1;
      wait_pulse(1, n, v);
      chk("k1_rel_vec", 32'(v), 32'h2);
      tick();

      // 4: long press on key2 with a 3-cycle release glitch before and after key_long
      snap = release_cnt[2];
      key_n[2] = 1'b0;
      wait_pulse(0, n, v);
      chk("k2_press_vec", 32'(v), 32'h4);
      repeat (10) tick();
      key_n[2] = 1'b1;
      repeat (3) tick();
      key_n[2] = 1'b0;
      // glitch removes 4 hold increments; 13 edges already elapsed since press
      wait_pulse(2, n, v);
      chk("k2_long_lat", 32'(n), 32'(c_LONG + 4 - 13));
      chk("k2_long_vec", 32'(v), 32'h4);
      tick();
      chk("k2_long_width", 32'(key_long), 32'h0);
      key_n[2] = 1'b1;
      repeat (3) tick();
      key_n[2] = 1'b0;
      repeat (20) tick();
      chk("k2_long_once",  32'(long_cnt[2]), 32'h1);
      chk("k2_no_release", 32'(release_cnt[2] - snap), 32'h0);
      chk("k2_state_held", 32'(key_state[2]), 32'h1);
      key_n[2] = 1'b1;
      wait_pulse(1, n, v);
      chk("k2_rel_lat", 32'(n), 32'(c_LAT));
      chk("k2_rel_vec", 32'(v), 32'h4);
      tick();

      // 5: key0 and key3 on the same edge
      key_n = 4'b0110;
      wait_pulse(0, n, v);
      chk("sim_press_lat", 32'(n), 32'(c_LAT));
      chk("sim_press_vec", 32'(v), 32'h9);
      key_n = 4'b1111;
      wait_pulse(1, n, v);
      chk("sim_rel_vec", 32'(v), 32'h9);
      tick();

      // 6: asynchronous reset while key1 is held
      key_n[1] = 1'b0;
      wait_pulse(0, n, v);
      chk("k1r_press_vec", 32'(v), 32'h2);
      repeat (20) tick();
      snap = release_cnt[1];
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_state", 32'(key_state), 32'h0);
      chk("mid_rst_pulse", 32'({key_press, key_release, key_long}), 32'h0);
      repeat (2) tick();
      chk("mid_rst_no_rel", 32'(release_cnt[1] - snap), 32'h0);
      rstn = 1'b1;
      wait_pulse(0, n, v);
      chk("k1r_repress_lat", 32'(n), 32'(c_LAT));
      chk("k1r_repress_vec", 32'(v), 32'h2);
      key_n[1] = 1'b1;
      wait_pulse(1, n, v);
      chk("k1r_rel_vec", 32'(v), 32'h2);
      repeat (3) tick();

      chk("no_overlap",  32'(overlap_cnt), 32'h0);
      chk("long_others", 32'(long_cnt[0] + long_cnt[1] + long_cnt[3]), 32'h0);
      chk("final_state", 32'(key_state), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_key_debounce

`default_nettype wire
